// File: rtl/mmio_timer_pwm_if.sv
// mmio_timer_pwm_if
// CPU data-memory bus as seen by a memory-mapped responder.
//   dmem_address  : byte address from the CPU
//   dmem_data_in  : store data, lane 0 in bits [7:0]
//   dmem_wren     : store strobe
//   funct3        : access size / sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   dmem_data_out : registered read data from the responder
//   sel           : registered "previous address hit this responder"
interface mmio_timer_pwm_if;
  logic [31:0] dmem_address;
  logic [31:0] dmem_data_in;
  logic        dmem_wren;
  logic [2:0]  funct3;
  logic [31:0] dmem_data_out;
  logic        sel;

  modport master (
    output dmem_address, dmem_data_in, dmem_wren, funct3,
    input  dmem_data_out, sel
  );

  modport slave (
    input  dmem_address, dmem_data_in, dmem_wren, funct3,
    output dmem_data_out, sel
  );
endinterface

// File: rtl/mmio_timer_pwm.sv
// mmio_timer_pwm
// Memory-mapped timer and LED PWM peripheral on the CPU data bus.
// Register window (16 bytes at BASE_ADDR):
//   0x0 DUTY   RW  [7:0] led, [15:8] red, [23:16] green, [31:24] blue
//   0x4 MICROS RO  free-running microsecond counter
//   0x8 MILLIS RO  free-running millisecond counter
//   0xC CTRL   RW  bit0 pwm_en, bit1 clr (write-1 pulse, reads 0)
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   bus (slave modport) : CPU data-memory bus, 1-cycle registered reads
//   led, red, green, blue : PWM LED drives (low when lit if ACTIVE_LOW)
module mmio_timer_pwm #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
  parameter int          CLK_HZ     = 12000000,
  parameter int          PWM_DIV    = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  mmio_timer_pwm_if.slave  bus,
  output logic             led,
  output logic             red,
  output logic             green,
  output logic             blue
);

  localparam logic [31:0] US_LAST  = 32'(CLK_HZ / 1000000 - 1);
  localparam logic [31:0] PWM_LAST = 32'(PWM_DIV - 1);
  localparam logic [9:0]  MS_LAST  = 10'd999;
  localparam logic        UNLIT    = ACTIVE_LOW;

  logic [31:0] duty_q, duty_d;
  logic        pwm_en_q, pwm_en_d;
  logic [31:0] us_pre_q, us_pre_d;
  logic [9:0]  ms_pre_q, ms_pre_d;
  logic [31:0] micros_q, micros_d;
  logic [31:0] millis_q, millis_d;
  logic [31:0] pwm_div_q, pwm_div_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [31:0] dout_q, dout_d;
  logic        sel_q, sel_d;
  logic        led_q, led_d, red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic        hit, aligned, wr_en, clr, us_tick, pwm_wrap;
  logic [1:0]  offset, lane;
  logic [31:0] wr_mask, wr_data, word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] rdata;

  assign hit    = bus.dmem_address[31:4] == BASE_ADDR[31:4];
  assign offset = bus.dmem_address[3:2];
  assign lane   = bus.dmem_address[1:0];

  // Access alignment; funct3[1:0]==11 is not a valid size and is treated as misaligned.
  always_comb begin
    aligned = 1'b0;
    case (bus.funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~lane[0];
      2'b10:   aligned = (lane == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign wr_en = bus.dmem_wren & hit & aligned;

  // Store data arrives right-justified and is steered to its byte lanes.
  always_comb begin
    wr_mask = '0;
    wr_data = '0;
    case (bus.funct3[1:0])
      2'b00: begin
        wr_mask = 32'h0000_00FF << {lane, 3'b000};
        wr_data = {24'b0, bus.dmem_data_in[7:0]} << {lane, 3'b000};
      end
      2'b01: begin
        wr_mask = 32'h0000_FFFF << {lane[1], 4'b0000};
        wr_data = {16'b0, bus.dmem_data_in[15:0]} << {lane[1], 4'b0000};
      end
      2'b10: begin
        wr_mask = 32'hFFFF_FFFF;
        wr_data = bus.dmem_data_in;
      end
      default: begin
        wr_mask = '0;
        wr_data = '0;
      end
    endcase
  end

  // Read path uses pre-edge register values, so a same-cycle write is not visible yet.
  always_comb begin
    word = '0;
    case (offset)
      2'd0: word = duty_q;
      2'd1: word = micros_q;
      2'd2: word = millis_q;
      2'd3: word = {31'b0, pwm_en_q};
      default: word = '0;
    endcase
    byte_v = word[{lane, 3'b000} +: 8];
    half_v = word[{lane[1], 4'b0000} +: 16];
    rdata  = '0;
    if (hit && aligned) begin
      case (bus.funct3[1:0])
        2'b00:   rdata = {{24{~bus.funct3[2] & byte_v[7]}}, byte_v};
        2'b01:   rdata = {{16{~bus.funct3[2] & half_v[15]}}, half_v};
        2'b10:   rdata = word;
        default: rdata = '0;
      endcase
    end
  end

  // Next-state for timebase, registers and PWM; clr overrides any timebase increment.
  always_comb begin
    duty_d    = duty_q;
    pwm_en_d  = pwm_en_q;
    clr       = 1'b0;

    us_tick   = (us_pre_q == US_LAST);
    us_pre_d  = us_tick ? '0 : us_pre_q + 32'd1;
    micros_d  = micros_q + {31'b0, us_tick};
    ms_pre_d  = ms_pre_q;
    millis_d  = millis_q;
    if (us_tick) begin
      if (ms_pre_q == MS_LAST) begin
        ms_pre_d = '0;
        millis_d = millis_q + 32'd1;
      end else begin
        ms_pre_d = ms_pre_q + 10'd1;
      end
    end

    if (wr_en && offset == 2'd0) begin
      duty_d = (duty_q & ~wr_mask) | (wr_data & wr_mask);
    end
    if (wr_en && offset == 2'd3) begin
      if (wr_mask[0]) pwm_en_d = wr_data[0];
      clr = wr_mask[1] & wr_data[1];
    end

    if (clr) begin
      us_pre_d = '0;
      ms_pre_d = '0;
      micros_d = '0;
      millis_d = '0;
    end

    pwm_wrap  = (pwm_div_q == PWM_LAST);
    pwm_div_d = pwm_wrap ? '0 : pwm_div_q + 32'd1;
    pwm_cnt_d = pwm_cnt_q + {7'b0, pwm_wrap};

    // XOR with UNLIT folds in output polarity.
    led_d   = (pwm_en_q && (pwm_cnt_q < duty_q[7:0]))   ^ UNLIT;
    red_d   = (pwm_en_q && (pwm_cnt_q < duty_q[15:8]))  ^ UNLIT;
    green_d = (pwm_en_q && (pwm_cnt_q < duty_q[23:16])) ^ UNLIT;
    blue_d  = (pwm_en_q && (pwm_cnt_q < duty_q[31:24])) ^ UNLIT;

    dout_d = rdata;
    sel_d  = hit;
  end

  // State registers; reset drops any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_q    <= '0;
      pwm_en_q  <= 1'b0;
      us_pre_q  <= '0;
      ms_pre_q  <= '0;
      micros_q  <= '0;
      millis_q  <= '0;
      pwm_div_q <= '0;
      pwm_cnt_q <= '0;
      dout_q    <= '0;
      sel_q     <= 1'b0;
      led_q     <= UNLIT;
      red_q     <= UNLIT;
      green_q   <= UNLIT;
      blue_q    <= UNLIT;
    end else begin
      duty_q    <= duty_d;
      pwm_en_q  <= pwm_en_d;
      us_pre_q  <= us_pre_d;
      ms_pre_q  <= ms_pre_d;
      micros_q  <= micros_d;
      millis_q  <= millis_d;
      pwm_div_q <= pwm_div_d;
      pwm_cnt_q <= pwm_cnt_d;
      dout_q    <= dout_d;
      sel_q     <= sel_d;
      led_q     <= led_d;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign bus.dmem_data_out = dout_q;
  assign bus.sel           = sel_q;
  assign led               = led_q;
  assign red               = red_q;
  assign green             = green_q;
  assign blue              = blue_q;

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// tb_mmio_timer_pwm
// Self-checking bench for mmio_timer_pwm: a vector table of bus accesses
// with a read-data scoreboard, plus hand-written timebase, PWM and
// asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_mmio_timer_pwm;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                         F_BU = 3'b100, F_HU = 3'b101;

  logic clk = 1'b0;
  logic reset;
  logic led, red, green, blue;

  mmio_timer_pwm_if bus ();

  mmio_timer_pwm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .led   (led),
    .red   (red),
    .green (green),
    .blue  (blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wren;
    logic [2:0]  f3;
    bit          chk;
    bit          useModel;
    logic [31:0] expData;
    logic        expSel;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        sel;
    string       name;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];

  int nApplied = 0;
  int nFail    = 0;
  int cyc      = 0;
  int clrEdge  = 0;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one bus cycle; expected read data is queued now and checked after the edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w,
                               input logic [2:0] f, input bit chk, input logic [31:0] ed,
                               input logic es, input string nm);
    exp_t e;
    bus.dmem_address = a;
    bus.dmem_data_in = d;
    bus.dmem_wren    = w;
    bus.funct3       = f;
    if (chk) begin
      e.data = ed;
      e.sel  = es;
      e.name = nm;
      sbQ.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkOutput({e.name, " data"}, bus.dmem_data_out, e.data);
      checkOutput({e.name, " sel"}, {31'b0, bus.sel}, {31'b0, e.sel});
    end
  endtask

  task automatic idle();
    applyStimulus(32'h0, 32'h0, 1'b0, F_W, 1'b0, 32'h0, 1'b0, "idle");
  endtask

  task automatic countLit(input int n, output int cl, output int cr, output int cg, output int cb);
    cl = 0; cr = 0; cg = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      idle();
      if (led == 1'b0)   cl++;
      if (red == 1'b0)   cr++;
      if (green == 1'b0) cg++;
      if (blue == 1'b0)  cb++;
    end
  endtask

  task automatic addVec(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [2:0] f, input bit chk, input bit um,
                        input logic [31:0] ed, input logic es, input string nm);
    vec_t v;
    v.addr = a; v.data = d; v.wren = w; v.f3 = f; v.chk = chk;
    v.useModel = um; v.expData = ed; v.expSel = es; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic checkLeds(input string nm, input logic exp);
    checkOutput({nm, " led"},   {31'b0, led},   {31'b0, exp});
    checkOutput({nm, " red"},   {31'b0, red},   {31'b0, exp});
    checkOutput({nm, " green"}, {31'b0, green}, {31'b0, exp});
    checkOutput({nm, " blue"},  {31'b0, blue},  {31'b0, exp});
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cl, cr, cg, cb;
    logic [31:0] ed;

    addVec(BASE + 32'h0, 32'h8040_2010, 1'b1, F_W,  1'b0, 1'b0, 32'h0,         1'b0, "sw duty");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h8040_2010, 1'b1, "lw duty");
    addVec(BASE + 32'h3, 32'h0,         1'b0, F_B,  1'b1, 1'b0, 32'hFFFF_FF80, 1'b1, "lb +3");
    addVec(BASE + 32'h3, 32'h0,         1'b0, F_BU, 1'b1, 1'b0, 32'h0000_0080, 1'b1, "lbu +3");
    addVec(BASE + 32'h2, 32'h0,         1'b0, F_H,  1'b1, 1'b0, 32'hFFFF_8040, 1'b1, "lh +2");
    addVec(BASE + 32'h2, 32'h0,         1'b0, F_HU, 1'b1, 1'b0, 32'h0000_8040, 1'b1, "lhu +2");
    addVec(BASE + 32'h1, 32'h0,         1'b0, F_B,  1'b1, 1'b0, 32'h0000_0020, 1'b1, "lb +1");
    addVec(BASE + 32'h0, 32'h0,         1'b1, F_W,  1'b0, 1'b0, 32'h0,         1'b0, "sw duty 0");
    addVec(BASE + 32'h1, 32'h0000_00AB, 1'b1, F_B,  1'b0, 1'b0, 32'h0,         1'b0, "sb +1");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h0000_AB00, 1'b1, "lw after sb");
    addVec(BASE + 32'h1, 32'h0000_1234, 1'b1, F_H,  1'b1, 1'b0, 32'h0,         1'b1, "sh misaligned");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h0000_AB00, 1'b1, "lw after bad sh");
    addVec(BASE + 32'h2, 32'hDEAD_BEEF, 1'b1, F_W,  1'b1, 1'b0, 32'h0,         1'b1, "sw misaligned");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h0000_AB00, 1'b1, "lw after bad sw");
    addVec(BASE + 32'h4, 32'h1234_5678, 1'b1, F_W,  1'b0, 1'b0, 32'h0,         1'b0, "sw micros");
    addVec(BASE + 32'h4, 32'h0,         1'b0, F_W,  1'b1, 1'b1, 32'h0,         1'b1, "lw micros");
    addVec(BASE + 32'h0, 32'hCAFE_BABE, 1'b1, F_W,  1'b1, 1'b0, 32'h0000_AB00, 1'b1, "read during write");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'hCAFE_BABE, 1'b1, "lw new duty");
    addVec(BASE + 32'h10, 32'h0,        1'b0, F_W,  1'b1, 1'b0, 32'h0,         1'b0, "lw miss");
    addVec(BASE + 32'h10, 32'hFFFF_FFFF, 1'b1, F_W, 1'b1, 1'b0, 32'h0,         1'b0, "sw miss");
    addVec(BASE + 32'h0, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'hCAFE_BABE, 1'b1, "lw after miss");
    addVec(BASE + 32'hC, 32'h1,         1'b1, F_W,  1'b0, 1'b0, 32'h0,         1'b0, "sw ctrl en");
    addVec(BASE + 32'hC, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h1,         1'b1, "lw ctrl");
    addVec(BASE + 32'hD, 32'hFF,        1'b1, F_B,  1'b0, 1'b0, 32'h0,         1'b0, "sb ctrl lane1");
    addVec(BASE + 32'hC, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h1,         1'b1, "lw ctrl after sb");
    addVec(BASE + 32'hC, 32'h0,         1'b1, F_W,  1'b0, 1'b0, 32'h0,         1'b0, "sw ctrl off");
    addVec(BASE + 32'hC, 32'h0,         1'b0, F_W,  1'b1, 1'b0, 32'h0,         1'b1, "lw ctrl off");

    // Power-on reset state.
    reset = 1'b1;
    bus.dmem_address = '0;
    bus.dmem_data_in = '0;
    bus.dmem_wren    = 1'b0;
    bus.funct3       = F_W;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset dout", bus.dmem_data_out, 32'h0);
    checkOutput("reset sel", {31'b0, bus.sel}, 32'h0);
    checkLeds("reset", 1'b1);
    reset = 1'b0;
    cyc = 0;

    // Timebase: 12000 edges from reset give 1000 us and 1 ms.
    repeat (12000) idle();
    applyStimulus(BASE + 32'h4, 32'h0, 1'b0, F_W, 1'b1, 32'd1000, 1'b1, "micros @12000");
    applyStimulus(BASE + 32'h8, 32'h0, 1'b0, F_W, 1'b1, 32'd1,    1'b1, "millis @12000");

    // clr on a microsecond terminal-count edge must win over the increment.
    while (cyc % 12 != 11) idle();
    clrEdge = cyc + 1;
    applyStimulus(BASE + 32'hC, 32'h2, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw clr");
    ed = 32'((cyc - clrEdge) / 12);
    applyStimulus(BASE + 32'h4, 32'h0, 1'b0, F_W, 1'b1, ed,   1'b1, "micros after clr");
    applyStimulus(BASE + 32'h8, 32'h0, 1'b0, F_W, 1'b1, 32'h0, 1'b1, "millis after clr");
    applyStimulus(BASE + 32'hC, 32'h0, 1'b0, F_W, 1'b1, 32'h0, 1'b1, "ctrl after clr");

    // Register access vectors.
    foreach (vecs[i]) begin
      ed = vecs[i].expData;
      if (vecs[i].useModel) ed = 32'((cyc - clrEdge) / 12);
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].wren, vecs[i].f3,
                    vecs[i].chk, ed, vecs[i].expSel, vecs[i].name);
    end

    // PWM: red duty 64 lights 256 of every 1024 clocks.
    applyStimulus(BASE, 32'h0000_4000, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw duty red64");
    applyStimulus(BASE + 32'hC, 32'h1, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw ctrl en");
    idle();
    countLit(1024, cl, cr, cg, cb);
    checkOutput("pwm red64 red", 32'(cr), 32'd256);
    checkOutput("pwm red64 led", 32'(cl), 32'd0);
    checkOutput("pwm red64 green", 32'(cg), 32'd0);
    checkOutput("pwm red64 blue", 32'(cb), 32'd0);

    applyStimulus(BASE, 32'h0, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw duty 0");
    idle();
    countLit(1024, cl, cr, cg, cb);
    checkOutput("pwm duty0 red", 32'(cr), 32'd0);

    applyStimulus(BASE, 32'hFFFF_FFFF, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw duty ff");
    idle();
    countLit(1024, cl, cr, cg, cb);
    checkOutput("pwm duty255 led", 32'(cl), 32'd1020);
    checkOutput("pwm duty255 blue", 32'(cb), 32'd1020);

    applyStimulus(BASE + 32'hC, 32'h0, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw ctrl off");
    idle();
    checkLeds("pwm disabled", 1'b1);
    countLit(64, cl, cr, cg, cb);
    checkOutput("pwm disabled lit count", 32'(cl + cr + cg + cb), 32'd0);

    // Asynchronous reset mid-cycle with a write in flight.
    applyStimulus(BASE + 32'hC, 32'h1, 1'b1, F_W, 1'b0, 32'h0, 1'b0, "sw ctrl en");
    applyStimulus(BASE, 32'h0, 1'b0, F_W, 1'b1, 32'hFFFF_FFFF, 1'b1, "lw duty pre-reset");
    bus.dmem_address = BASE;
    bus.dmem_data_in = 32'h1111_1111;
    bus.dmem_wren    = 1'b1;
    bus.funct3       = F_W;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async reset dout", bus.dmem_data_out, 32'h0);
    checkOutput("async reset sel", {31'b0, bus.sel}, 32'h0);
    checkLeds("async reset", 1'b1);
    @(posedge clk);
    #1;
    checkOutput("reset held dout", bus.dmem_data_out, 32'h0);
    reset = 1'b0;
    applyStimulus(BASE, 32'h0, 1'b0, F_W, 1'b1, 32'h0, 1'b1, "duty after reset");
    applyStimulus(BASE + 32'hC, 32'h0, 1'b0, F_W, 1'b1, 32'h0, 1'b1, "ctrl after reset");
    checkLeds("after reset", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
